// File: rtl/imem_loader.sv
// Instruction-memory front end for the Mips32 core: packs a little-endian byte stream into
// 32-bit words, then serves instructions and releases the core from reset after a hold period.
module imem_loader #(
    parameter int unsigned ADDR_SIZE  = 6,
    parameter int unsigned RESET_HOLD = 4,
    parameter logic [31:0] HALT_WORD  = 32'h0000000D
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    input  logic [31:0]          raddr,
    output logic [31:0]          instr,
    output logic                 core_reset,
    output logic                 load_done,
    output logic                 error,
    output logic [ADDR_SIZE:0]   word_count
);

    localparam int unsigned Depth = 2 ** ADDR_SIZE;
    localparam int unsigned HoldW = $clog2(RESET_HOLD) + 1;
    localparam logic [ADDR_SIZE:0] Full     = (ADDR_SIZE + 1)'(Depth);
    localparam logic [HoldW-1:0]   HoldLast = HoldW'(RESET_HOLD - 1);

    typedef enum logic [1:0] {StLoad, StHold, StRun, StError} state_e;

    state_e               state_q, state_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [23:0]          asm_q, asm_d;
    logic [ADDR_SIZE:0]   word_count_q, word_count_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic                 in_ready_q, in_ready_d;
    logic                 core_reset_q, core_reset_d;
    logic                 load_done_q, load_done_d;
    logic                 error_q, error_d;
    logic                 mem_we;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem [Depth];

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        hold_d       = hold_q;
        mem_we       = 1'b0;
        mem_wdata    = {in_data, asm_q};

        unique case (state_q)
            StLoad: begin
                if (in_valid && in_ready_q) begin
                    // A full store discards the byte instead of wrapping onto word 0.
                    if (word_count_q == Full) begin
                        state_d = StError;
                    end else begin
                        unique case (byte_idx_q)
                            2'd0: asm_d[7:0]   = in_data;
                            2'd1: asm_d[15:8]  = in_data;
                            2'd2: asm_d[23:16] = in_data;
                            2'd3: begin
                                mem_we       = 1'b1;
                                word_count_d = word_count_q + (ADDR_SIZE + 1)'(1);
                            end
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                        hold_d     = '0;
                        if (in_last) begin
                            state_d = (byte_idx_q == 2'd3) ? StHold : StError;
                        end
                    end
                end
            end
            StHold: begin
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StRun:   state_d = StRun;
            StError: state_d = StError;
        endcase

        if (reset) begin
            state_d      = StLoad;
            byte_idx_d   = 2'd0;
            word_count_d = '0;
            hold_d       = '0;
            mem_we       = 1'b0;
        end

        // Outputs are registered from the next state so they never depend on in_valid.
        in_ready_d   = (state_d == StLoad);
        core_reset_d = (state_d != StRun);
        load_done_d  = (state_d == StHold) || (state_d == StRun);
        error_d      = (state_d == StError);
    end

    always_ff @(posedge clock) begin
        state_q      <= state_d;
        byte_idx_q   <= byte_idx_d;
        asm_q        <= asm_d;
        word_count_q <= word_count_d;
        hold_q       <= hold_d;
        in_ready_q   <= in_ready_d;
        core_reset_q <= core_reset_d;
        load_done_q  <= load_done_d;
        error_q      <= error_d;
    end

    // Storage is never cleared; the word_count compare masks stale contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[word_count_q[ADDR_SIZE-1:0]] <= mem_wdata;
        end
    end

    always_comb begin
        instr = HALT_WORD;
        if (((state_q == StRun) || (state_q == StHold)) && (raddr < 32'(word_count_q))) begin
            instr = mem[raddr[ADDR_SIZE-1:0]];
        end
    end

    assign in_ready   = in_ready_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a default-size instance for most scenarios and an
// ADDR_SIZE=2 instance for overflow; loaded words are queued and compared on read-back.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam logic [31:0] Halt = 32'h0000000D;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [31:0] raddr = 32'h0;
    logic        sel = 1'b0;

    logic        b_valid, b_ready, b_core_reset, b_load_done, b_error;
    logic [31:0] b_instr;
    logic [6:0]  b_word_count;
    logic        s_valid, s_ready, s_core_reset, s_load_done, s_error;
    logic [31:0] s_instr;
    logic [2:0]  s_word_count;
    logic        ready_m;

    assign b_valid = in_valid & ~sel;
    assign s_valid = in_valid & sel;
    assign ready_m = sel ? s_ready : b_ready;

    imem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (b_valid),
        .in_ready   (b_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .raddr      (raddr),
        .instr      (b_instr),
        .core_reset (b_core_reset),
        .load_done  (b_load_done),
        .error      (b_error),
        .word_count (b_word_count)
    );

    imem_loader #(.ADDR_SIZE(2)) dut_small (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (s_valid),
        .in_ready   (s_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .raddr      (raddr),
        .instr      (s_instr),
        .core_reset (s_core_reset),
        .load_done  (s_load_done),
        .error      (s_error),
        .word_count (s_word_count)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fails = 0;
    logic [31:0] words [64];
    logic [31:0] exp_q [$];

    // Offer one byte after an optional idle gap; ok reports whether it was taken in time.
    task automatic send(input logic [7:0] d, input logic last, input int gap, output bit ok);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok       = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = ready_m;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_image(input int n, input int max_gap, output bit ok);
        bit b;
        int gap;
        ok = 1'b1;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                send(words[w][8*k +: 8], (w == n - 1) && (k == 3), gap, b);
                if (!b) ok = 1'b0;
                if (k == 3) exp_q.push_back(words[w]);
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        raddr = 32'h0;
        do_reset();
        @(negedge clock);
        n_checks++; if (b_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b want 1", b_ready); end
        n_checks++; if (b_core_reset !== 1'b1) begin n_fails++; $display("FAIL reset_core_reset: got %b want 1", b_core_reset); end
        n_checks++; if (b_load_done !== 1'b0) begin n_fails++; $display("FAIL reset_load_done: got %b want 0", b_load_done); end
        n_checks++; if (b_error !== 1'b0) begin n_fails++; $display("FAIL reset_error: got %b want 0", b_error); end
        n_checks++; if (b_word_count !== 7'd0) begin n_fails++; $display("FAIL reset_word_count: got %0d want 0", b_word_count); end
        n_checks++; if (b_instr !== Halt) begin n_fails++; $display("FAIL reset_instr: got %h want %h", b_instr, Halt); end
    endtask

    task automatic test_three_word();
        bit ok;
        logic [31:0] e;
        do_reset();
        words[0] = 32'h0000000D;
        words[1] = 32'h20080004;
        words[2] = 32'h0000000D;
        load_image(3, 0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL three_accept: got %b want 1", ok); end
        @(negedge clock);
        n_checks++; if (b_word_count !== 7'd3) begin n_fails++; $display("FAIL three_word_count: got %0d want 3", b_word_count); end
        n_checks++; if (b_load_done !== 1'b1) begin n_fails++; $display("FAIL three_load_done: got %b want 1", b_load_done); end
        n_checks++; if (b_ready !== 1'b0) begin n_fails++; $display("FAIL three_in_ready: got %b want 0", b_ready); end
        n_checks++; if (b_core_reset !== 1'b1) begin n_fails++; $display("FAIL three_hold0: got %b want 1", b_core_reset); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            n_checks++; if (b_core_reset !== 1'b1) begin n_fails++; $display("FAIL three_hold%0d: got %b want 1", k, b_core_reset); end
        end
        @(negedge clock);
        n_checks++; if (b_core_reset !== 1'b0) begin n_fails++; $display("FAIL three_release: got %b want 0", b_core_reset); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            raddr = i;
            #1;
            n_checks++; if (b_instr !== e) begin n_fails++; $display("FAIL three_read%0d: got %h want %h", i, b_instr, e); end
        end
        raddr = 32'd1;
        #1;
        n_checks++; if (b_instr !== 32'h20080004) begin n_fails++; $display("FAIL three_raddr1: got %h want 20080004", b_instr); end
        raddr = 32'd3;
        #1;
        n_checks++; if (b_instr !== Halt) begin n_fails++; $display("FAIL three_raddr3: got %h want %h", b_instr, Halt); end
    endtask

    task automatic test_partial();
        bit ok, all_ok;
        do_reset();
        all_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(8'h10 + 8'(i), i == 5, 0, ok);
            if (!ok) all_ok = 1'b0;
        end
        n_checks++; if (all_ok !== 1'b1) begin n_fails++; $display("FAIL partial_accept: got %b want 1", all_ok); end
        @(negedge clock);
        n_checks++; if (b_error !== 1'b1) begin n_fails++; $display("FAIL partial_error: got %b want 1", b_error); end
        n_checks++; if (b_word_count !== 7'd1) begin n_fails++; $display("FAIL partial_word_count: got %0d want 1", b_word_count); end
        n_checks++; if (b_core_reset !== 1'b1) begin n_fails++; $display("FAIL partial_core_reset: got %b want 1", b_core_reset); end
        n_checks++; if (b_ready !== 1'b0) begin n_fails++; $display("FAIL partial_in_ready: got %b want 0", b_ready); end
        n_checks++; if (b_load_done !== 1'b0) begin n_fails++; $display("FAIL partial_load_done: got %b want 0", b_load_done); end
        raddr = 32'd0;
        #1;
        n_checks++; if (b_instr !== Halt) begin n_fails++; $display("FAIL partial_instr: got %h want %h", b_instr, Halt); end
    endtask

    task automatic test_overflow();
        bit ok, all_ok;
        sel = 1'b1;
        do_reset();
        all_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0, 0, ok);
            if (!ok) all_ok = 1'b0;
        end
        @(negedge clock);
        n_checks++; if (all_ok !== 1'b1) begin n_fails++; $display("FAIL ovf_accept: got %b want 1", all_ok); end
        n_checks++; if (s_error !== 1'b0) begin n_fails++; $display("FAIL ovf_error16: got %b want 0", s_error); end
        n_checks++; if (s_word_count !== 3'd4) begin n_fails++; $display("FAIL ovf_count16: got %0d want 4", s_word_count); end
        send(8'hFF, 1'b0, 0, ok);
        @(negedge clock);
        n_checks++; if (s_error !== 1'b1) begin n_fails++; $display("FAIL ovf_error17: got %b want 1", s_error); end
        n_checks++; if (s_word_count !== 3'd4) begin n_fails++; $display("FAIL ovf_count17: got %0d want 4", s_word_count); end
        n_checks++; if (s_load_done !== 1'b0) begin n_fails++; $display("FAIL ovf_load_done: got %b want 0", s_load_done); end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        words[2] = 32'hDEADBEEF;
        load_image(6, 2, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL bp_accept: got %b want 1", ok); end
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        repeat (8) @(posedge clock);
        @(negedge clock);
        n_checks++; if (b_word_count !== 7'd6) begin n_fails++; $display("FAIL bp_word_count: got %0d want 6", b_word_count); end
        n_checks++; if (b_load_done !== 1'b1) begin n_fails++; $display("FAIL bp_load_done: got %b want 1", b_load_done); end
        n_checks++; if (b_error !== 1'b0) begin n_fails++; $display("FAIL bp_error: got %b want 0", b_error); end
        n_checks++; if (b_core_reset !== 1'b0) begin n_fails++; $display("FAIL bp_core_reset: got %b want 0", b_core_reset); end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            raddr = i;
            #1;
            n_checks++; if (b_instr !== e) begin n_fails++; $display("FAIL bp_read%0d: got %h want %h", i, b_instr, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0, 0, ok);
        // Reset coincides with an offered byte; the byte must be dropped.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        in_last  = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        n_checks++; if (b_word_count !== 7'd0) begin n_fails++; $display("FAIL mid_wc_after_reset: got %0d want 0", b_word_count); end
        n_checks++; if (b_ready !== 1'b1) begin n_fails++; $display("FAIL mid_in_ready: got %b want 1", b_ready); end
        exp_q.delete();
        words[0] = 32'h11223344;
        words[1] = 32'h8C080000;
        load_image(2, 0, ok);
        @(negedge clock);
        n_checks++; if (b_word_count !== 7'd2) begin n_fails++; $display("FAIL mid_word_count: got %0d want 2", b_word_count); end
        raddr = 32'd2;
        #1;
        n_checks++; if (b_instr !== Halt) begin n_fails++; $display("FAIL mid_stale: got %h want %h", b_instr, Halt); end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            raddr = i;
            #1;
            n_checks++; if (b_instr !== e) begin n_fails++; $display("FAIL mid_read%0d: got %h want %h", i, b_instr, e); end
        end
        repeat (4) @(negedge clock);
        n_checks++; if (b_core_reset !== 1'b0) begin n_fails++; $display("FAIL mid_run: got %b want 0", b_core_reset); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        raddr = 32'd0;
        @(negedge clock);
        n_checks++; if (b_core_reset !== 1'b1) begin n_fails++; $display("FAIL run_reset_core: got %b want 1", b_core_reset); end
        n_checks++; if (b_load_done !== 1'b0) begin n_fails++; $display("FAIL run_reset_done: got %b want 0", b_load_done); end
        n_checks++; if (b_instr !== Halt) begin n_fails++; $display("FAIL run_reset_instr: got %h want %h", b_instr, Halt); end
    endtask

    task automatic test_out_of_range();
        bit ok;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 64; i++) words[i] = {8'(i), 8'h5A, 8'(~i), 8'hC3};
        load_image(64, 0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fails++; $display("FAIL oor_accept: got %b want 1", ok); end
        @(negedge clock);
        n_checks++; if (b_word_count !== 7'd64) begin n_fails++; $display("FAIL oor_word_count: got %0d want 64", b_word_count); end
        n_checks++; if (b_error !== 1'b0) begin n_fails++; $display("FAIL oor_error: got %b want 0", b_error); end
        for (int i = 0; i < 64; i++) begin
            e = exp_q.pop_front();
            raddr = i;
            #1;
            if (i == 0 || i == 63 || b_instr !== e) begin
                n_checks++;
                if (b_instr !== e) begin n_fails++; $display("FAIL oor_read%0d: got %h want %h", i, b_instr, e); end
            end
        end
        raddr = 32'h00000040;
        #1;
        n_checks++; if (b_instr !== Halt) begin n_fails++; $display("FAIL oor_addr40: got %h want %h", b_instr, Halt); end
        raddr = 32'h80000000;
        #1;
        n_checks++; if (b_instr !== Halt) begin n_fails++; $display("FAIL oor_addr80000000: got %h want %h", b_instr, Halt); end
    endtask

    initial begin
        test_reset();
        test_three_word();
        test_partial();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
